// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg -- shared serial-transmitter state encoding and line-level constants
// Revision 1.0
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo -- single-clock FIFO with registered full/empty/count flags
// Revision 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     NCLR,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_next;
    logic             wr_fire;
    logic             rd_fire;

    // A write into a full FIFO is refused even if a pop frees a slot this cycle
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;

    always_comb begin
        count_next = count;
        case ({wr_fire, rd_fire})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NCLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (NCLR && wr_fire) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule : sync_fifo
`default_nettype wire

// File: rtl/serial_out_fifo_tx.sv
`default_nettype none
// ============================================================================
// serial_out_fifo_tx -- buffered framed serialiser for the SERIAL_OUT pin
// Revision 1.0
// ============================================================================
module serial_out_fifo_tx
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 4,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 0,
    parameter int MSB_FIRST  = 0
) (
    input  logic                     CLK,
    input  logic                     NCLR,
    input  logic                     WR_EN,
    input  logic [DATA_W-1:0]        WR_DATA,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     SERIAL_OUT
);

    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [CYC_W-1:0]  cyc_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic              parity_bit;
    logic              parity_next;
    logic              serial_next;
    logic              done_next;
    logic              busy_next;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic              last_cyc;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .NCLR    (NCLR),
        .wr_en   (WR_EN),
        .wr_data (WR_DATA),
        .rd_en   (pop),
        .rd_data (head),
        .full    (FULL),
        .empty   (EMPTY),
        .count   (COUNT)
    );

    assign last_cyc = (cyc_cnt == CYC_LAST);

    always_comb begin
        state_next  = state;
        cyc_next    = cyc_cnt;
        bit_next    = bit_cnt;
        shreg_next  = shreg;
        parity_next = parity_bit;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                if (!EMPTY) begin
                    pop         = 1'b1;
                    shreg_next  = head;
                    parity_next = ^head;
                    cyc_next    = '0;
                    bit_next    = '0;
                    state_next  = START;
                end
            end
            START: begin
                if (last_cyc) begin
                    cyc_next   = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    cyc_next = cyc_cnt + CYC_ONE;
                end
            end
            DATA: begin
                if (last_cyc) begin
                    cyc_next   = '0;
                    shreg_next = (MSB_FIRST != 0) ? {shreg[DATA_W-2:0], 1'b0}
                                                  : {1'b0, shreg[DATA_W-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_next = bit_cnt + BIT_ONE;
                    end
                end else begin
                    cyc_next = cyc_cnt + CYC_ONE;
                end
            end
            PARITY: begin
                if (last_cyc) begin
                    cyc_next   = '0;
                    state_next = STOP;
                end else begin
                    cyc_next = cyc_cnt + CYC_ONE;
                end
            end
            STOP: begin
                if (last_cyc) begin
                    cyc_next = '0;
                    // Chain straight into the next frame so queued words leave no gap
                    if (!EMPTY) begin
                        pop         = 1'b1;
                        shreg_next  = head;
                        parity_next = ^head;
                        bit_next    = '0;
                        state_next  = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cyc_next = cyc_cnt + CYC_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level and flags are computed from the next state so they are registered
    always_comb begin
        serial_next = LINE_IDLE;
        case (state_next)
            IDLE:    serial_next = LINE_IDLE;
            START:   serial_next = START_BIT;
            DATA:    serial_next = (MSB_FIRST != 0) ? shreg_next[DATA_W-1] : shreg_next[0];
            PARITY:  serial_next = parity_next;
            STOP:    serial_next = STOP_BIT;
            default: serial_next = LINE_IDLE;
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_next == STOP) && (cyc_next == CYC_LAST);
    end

    always_ff @(posedge CLK) begin
        if (!NCLR) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            SERIAL_OUT <= LINE_IDLE;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            state      <= state_next;
            cyc_cnt    <= cyc_next;
            bit_cnt    <= bit_next;
            shreg      <= shreg_next;
            parity_bit <= parity_next;
            SERIAL_OUT <= serial_next;
            BUSY       <= busy_next;
            DONE       <= done_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (!NCLR) begin
            OVERFLOW <= 1'b0;
        end else if (WR_EN && FULL) begin
            OVERFLOW <= 1'b1;
        end
    end

endmodule : serial_out_fifo_tx
`default_nettype wire

// File: tb/tb_serial_out_fifo_tx.sv
`default_nettype none
// ============================================================================
// tb_serial_out_fifo_tx -- two configurations (LSB/no parity, MSB/parity) side by side
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_serial_out_fifo_tx;

    localparam int DW  = 8;
    localparam int DEP = 4;
    localparam int BC  = 2;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          nclr = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [1:0]    full_o, empty_o, ovf_o, busy_o, done_o, ser_o;
    logic [CW-1:0] count_o [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_out_fifo_tx #(.DATA_W(DW), .DEPTH(DEP), .BIT_CYCLES(BC), .PARITY_EN(0), .MSB_FIRST(0)) u_lsb (
        .CLK(clk), .NCLR(nclr), .WR_EN(wr_en), .WR_DATA(wr_data),
        .FULL(full_o[0]), .EMPTY(empty_o[0]), .COUNT(count_o[0]), .OVERFLOW(ovf_o[0]),
        .BUSY(busy_o[0]), .DONE(done_o[0]), .SERIAL_OUT(ser_o[0]));

    serial_out_fifo_tx #(.DATA_W(DW), .DEPTH(DEP), .BIT_CYCLES(BC), .PARITY_EN(1), .MSB_FIRST(1)) u_msb (
        .CLK(clk), .NCLR(nclr), .WR_EN(wr_en), .WR_DATA(wr_data),
        .FULL(full_o[1]), .EMPTY(empty_o[1]), .COUNT(count_o[1]), .OVERFLOW(ovf_o[1]),
        .BUSY(busy_o[1]), .DONE(done_o[1]), .SERIAL_OUT(ser_o[1]));

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic int flen(input int d);
        return (d == 0) ? 10 : 11;
    endfunction

    // Reference frame, first-transmitted bit in the highest used position
    function automatic logic [10:0] exp_frame(input int d, input logic [7:0] w);
        logic [10:0] f;
        f = 11'd0;
        for (int i = 0; i < 8; i++) f = {f[9:0], (d == 1) ? w[7-i] : w[i]};
        if (d == 1) f = {f[9:0], ^w};
        f = {f[9:0], 1'b1};
        return f;
    endfunction

    // Scoreboard
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    task automatic push(input logic [7:0] w);
        q0.push_back(w);
        q1.push_back(w);
    endtask

    // Per-cycle statistics
    int   n_done [2];
    int   n_busy [2];
    int   peak   [2];
    logic pend   [2];
    logic aft_full  [2][8];
    logic aft_empty [2][8];

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            n_done[d] = 0; n_busy[d] = 0; peak[d] = 0; pend[d] = 1'b0;
            for (int k = 0; k < 8; k++) begin aft_full[d][k] = 1'b0; aft_empty[d][k] = 1'b0; end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (pend[d]) begin
                if (n_done[d] <= 8) begin
                    aft_full[d][n_done[d]-1]  = full_o[d];
                    aft_empty[d][n_done[d]-1] = empty_o[d];
                end
                pend[d] = 1'b0;
            end
            if (done_o[d]) begin n_done[d]++; pend[d] = 1'b1; end
            if (busy_o[d]) n_busy[d]++;
            if (int'(count_o[d]) > peak[d]) peak[d] = int'(count_o[d]);
        end
    endtask

    task automatic run_idle(input int budget);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while ((busy_o != 2'b00 || empty_o != 2'b11) && k < budget);
        check("idle_reached", 0, 32'(k < budget), 32'd1);
    endtask

    // Frame monitor: samples the first cycle of every bit
    logic       mon_act [2];
    int         mon_cyc [2];
    logic [10:0] mon_bits [2];
    logic [7:0] mon_w;
    int         mon_qs;

    initial begin
        for (int d = 0; d < 2; d++) begin mon_act[d] = 1'b0; mon_cyc[d] = 0; mon_bits[d] = '0; end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!nclr) begin
                    mon_act[d] = 1'b0;
                end else if (!mon_act[d]) begin
                    if (ser_o[d] == 1'b0) begin
                        mon_act[d] = 1'b1; mon_cyc[d] = 0; mon_bits[d] = '0;
                    end
                end else begin
                    mon_cyc[d]++;
                    if (mon_cyc[d] % BC == 0) begin
                        mon_bits[d] = {mon_bits[d][9:0], ser_o[d]};
                        if (mon_cyc[d] / BC + 1 == flen(d)) begin
                            mon_act[d] = 1'b0;
                            mon_qs = (d == 0) ? q0.size() : q1.size();
                            check("sb_word_expected", d, 32'(mon_qs > 0), 32'd1);
                            if (mon_qs > 0) begin
                                mon_w = (d == 0) ? q0.pop_front() : q1.pop_front();
                                check("sb_frame", d, 32'(mon_bits[d]), 32'(exp_frame(d, mon_w)));
                            end
                        end
                    end
                end
            end
        end
    end

    typedef struct packed {
        logic [7:0]  data;
        logic [9:0]  exp_lsb;
        logic [10:0] exp_msb;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_s;
        vecs[0] = '{data: 8'hA5, exp_lsb: 10'b0101001011, exp_msb: 11'b01010010101};
        vecs[1] = '{data: 8'h07, exp_lsb: 10'b0111000001, exp_msb: 11'b00000011111};
        vecs[2] = '{data: 8'h00, exp_lsb: 10'b0000000001, exp_msb: 11'b00000000001};
        vecs[3] = '{data: 8'hFF, exp_lsb: 10'b0111111111, exp_msb: 11'b01111111101};
        vecs[4] = '{data: 8'h80, exp_lsb: 10'b0000000011, exp_msb: 11'b01000000011};
        clear_stats();

        // Reset state
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_serial", d, 32'(ser_o[d]), 32'd1);
            check("rst_busy", d, 32'(busy_o[d]), 32'd0);
            check("rst_done", d, 32'(done_o[d]), 32'd0);
            check("rst_count", d, 32'(count_o[d]), 32'd0);
            check("rst_empty", d, 32'(empty_o[d]), 32'd1);
            check("rst_full", d, 32'(full_o[d]), 32'd0);
            check("rst_ovf", d, 32'(ovf_o[d]), 32'd0);
        end
        nclr = 1'b1;

        // Table-driven single frames with cycle-exact waveform
        for (int v = 0; v < 5; v++) begin
            clear_stats();
            tick();
            wr_en = 1'b1; wr_data = vecs[v].data; push(vecs[v].data);
            tick();
            wr_en = 1'b0;
            for (int d = 0; d < 2; d++) begin
                check("lat_count", d, 32'(count_o[d]), 32'd1);
                check("lat_idle_line", d, 32'(ser_o[d]), 32'd1);
            end
            for (int j = 0; j < 24; j++) begin
                tick();
                exp_s = 1'b1;
                if (j < 20) exp_s = vecs[v].exp_lsb[9 - j/2];
                check("tbl_serial", 0, 32'(ser_o[0]), 32'(exp_s));
                check("tbl_busy", 0, 32'(busy_o[0]), 32'(j < 20));
                check("tbl_done", 0, 32'(done_o[0]), 32'(j == 19));
                exp_s = 1'b1;
                if (j < 22) exp_s = vecs[v].exp_msb[10 - j/2];
                check("tbl_serial", 1, 32'(ser_o[1]), 32'(exp_s));
                check("tbl_busy", 1, 32'(busy_o[1]), 32'(j < 22));
                check("tbl_done", 1, 32'(done_o[1]), 32'(j == 21));
            end
            for (int d = 0; d < 2; d++) check("tbl_done_cnt", d, 32'(n_done[d]), 32'd1);
        end

        // Back-to-back writes
        clear_stats();
        tick();
        wr_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wr_data = 8'(i); push(8'(i));
            tick();
        end
        wr_en = 1'b0;
        run_idle(200);
        for (int d = 0; d < 2; d++) begin
            check("b2b_done_cnt", d, 32'(n_done[d]), 32'd3);
            check("b2b_busy_cycles", d, 32'(n_busy[d]), 32'(3 * flen(d) * BC));
            check("b2b_peak_count", d, 32'(peak[d]), 32'd2);
            check("b2b_empty_after_pop2", d, 32'(aft_empty[d][0]), 32'd0);
            check("b2b_empty_after_pop3", d, 32'(aft_empty[d][1]), 32'd1);
        end

        // Overflow: six writes, the last one dropped
        clear_stats();
        for (int d = 0; d < 2; d++) check("ovf_pre", d, 32'(ovf_o[d]), 32'd0);
        tick();
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(8'h10 + i);
            if (i < 5) push(8'(8'h10 + i));
            tick();
        end
        wr_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("ovf_flag", d, 32'(ovf_o[d]), 32'd1);
            check("ovf_full", d, 32'(full_o[d]), 32'd1);
            check("ovf_count", d, 32'(count_o[d]), 32'd4);
        end
        repeat (10) tick();
        for (int d = 0; d < 2; d++) begin
            check("ovf_full_held", d, 32'(full_o[d]), 32'd1);
            check("ovf_count_held", d, 32'(count_o[d]), 32'd4);
        end
        run_idle(400);
        for (int d = 0; d < 2; d++) begin
            check("ovf_done_cnt", d, 32'(n_done[d]), 32'd5);
            check("ovf_busy_cycles", d, 32'(n_busy[d]), 32'(5 * flen(d) * BC));
            check("ovf_full_after_pop", d, 32'(aft_full[d][0]), 32'd0);
            check("ovf_sticky", d, 32'(ovf_o[d]), 32'd1);
        end

        // Reset during DATA bit 3
        clear_stats();
        tick();
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_data = 8'h33;
        tick();
        wr_en = 1'b0;
        repeat (8) tick();
        for (int d = 0; d < 2; d++) check("mid_count_pre", d, 32'(count_o[d]), 32'd1);
        nclr = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            check("mid_serial", d, 32'(ser_o[d]), 32'd1);
            check("mid_count", d, 32'(count_o[d]), 32'd0);
            check("mid_busy", d, 32'(busy_o[d]), 32'd0);
            check("mid_ovf", d, 32'(ovf_o[d]), 32'd0);
            check("mid_empty", d, 32'(empty_o[d]), 32'd1);
            check("mid_done", d, 32'(done_o[d]), 32'd0);
        end
        q0.delete(); q1.delete();
        tick();
        nclr = 1'b1;
        for (int d = 0; d < 2; d++) check("mid_no_done", d, 32'(n_done[d]), 32'd0);
        tick();
        wr_en = 1'b1; wr_data = 8'h3C; push(8'h3C);
        tick();
        wr_en = 1'b0;
        run_idle(100);
        for (int d = 0; d < 2; d++) check("mid_recover_done", d, 32'(n_done[d]), 32'd1);

        // Wrap-around: ten spaced single words
        clear_stats();
        for (int i = 0; i < 10; i++) begin
            tick();
            wr_en = 1'b1; wr_data = 8'(i * 37 + 5); push(8'(i * 37 + 5));
            tick();
            wr_en = 1'b0;
            repeat (24) tick();
        end
        for (int d = 0; d < 2; d++) check("wrap_done_cnt", d, 32'(n_done[d]), 32'd10);

        repeat (4) tick();
        check("sb_drained", 0, 32'(q0.size()), 32'd0);
        check("sb_drained", 1, 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_out_fifo_tx
`default_nettype wire
